// File: rtl/times_table_seq_if.sv
// Request/response front end and AXI4-lite master bundle for the times-table sequencer.
// The master modport is the controller's view; slave is the requester/memory side.
interface times_table_seq_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic [2:0]        req_a;
  logic [2:0]        req_b;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [5:0]        rsp_result;
  logic              rsp_err;

  logic [ADDR_W-1:0] m_axi_awaddr;
  logic              m_axi_awvalid;
  logic              m_axi_awready;
  logic [DATA_W-1:0] m_axi_wdata;
  logic [3:0]        m_axi_wstrb;
  logic              m_axi_wvalid;
  logic              m_axi_wready;
  logic [1:0]        m_axi_bresp;
  logic              m_axi_bvalid;
  logic              m_axi_bready;
  logic [ADDR_W-1:0] m_axi_araddr;
  logic              m_axi_arvalid;
  logic              m_axi_arready;
  logic [DATA_W-1:0] m_axi_rdata;
  logic [1:0]        m_axi_rresp;
  logic              m_axi_rvalid;
  logic              m_axi_rready;

  modport master (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_err,
    output m_axi_awaddr, m_axi_awvalid, m_axi_wdata, m_axi_wstrb, m_axi_wvalid, m_axi_bready,
    output m_axi_araddr, m_axi_arvalid, m_axi_rready,
    input  m_axi_awready, m_axi_wready, m_axi_bresp, m_axi_bvalid,
    input  m_axi_arready, m_axi_rdata, m_axi_rresp, m_axi_rvalid
  );

  modport slave (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_err,
    input  m_axi_awaddr, m_axi_awvalid, m_axi_wdata, m_axi_wstrb, m_axi_wvalid, m_axi_bready,
    input  m_axi_araddr, m_axi_arvalid, m_axi_rready,
    output m_axi_awready, m_axi_wready, m_axi_bresp, m_axi_bvalid,
    output m_axi_arready, m_axi_rdata, m_axi_rresp, m_axi_rvalid
  );
endinterface

// File: rtl/times_table_seq.sv
// Fills an AXI4-lite block RAM with the 8x8 multiplication table after reset, then serves
// single-outstanding (a, b) lookups as one AXI read each. All outputs are registered.
module times_table_seq #(
  parameter bit          INIT_EN = 1'b1,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  times_table_seq_if.master bus,
  output logic              init_done,
  output logic              err_sticky
);

  typedef enum logic [2:0] {StWr, StWrResp, StRdIdle, StRdAddr, StRdData, StRsp} state_e;

  state_e            state_q, state_d;
  logic [5:0]        idx_q, idx_d;
  logic              aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic              awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
  logic              arvalid_q, arvalid_d, rready_q, rready_d;
  logic [ADDR_W-1:0] awaddr_q, awaddr_d, araddr_q, araddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              req_ready_q, req_ready_d, rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
  logic [5:0]        rsp_result_q, rsp_result_d;
  logic              init_done_q, init_done_d, err_sticky_q, err_sticky_d;
  logic              aw_fin, w_fin;
  logic              unused_rdata;

  assign unused_rdata = ^bus.m_axi_rdata[DATA_W-1:6];

  function automatic logic [5:0] product(input logic [5:0] i);
    return 6'(i[5:3]) * 6'(i[2:0]);
  endfunction

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    aw_done_d    = aw_done_q;
    w_done_d     = w_done_q;
    awvalid_d    = awvalid_q;
    wvalid_d     = wvalid_q;
    bready_d     = bready_q;
    arvalid_d    = arvalid_q;
    rready_d     = rready_q;
    awaddr_d     = awaddr_q;
    araddr_d     = araddr_q;
    wdata_d      = wdata_q;
    req_ready_d  = req_ready_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_result_d = rsp_result_q;
    rsp_err_d    = rsp_err_q;
    init_done_d  = init_done_q;
    err_sticky_d = err_sticky_q;
    aw_fin       = aw_done_q | (awvalid_q & bus.m_axi_awready);
    w_fin        = w_done_q | (wvalid_q & bus.m_axi_wready);

    case (state_q)
      StWr: begin
        // First entry after reset: nothing raised yet, so raise both valids together.
        if (!awvalid_q && !wvalid_q && !aw_done_q && !w_done_q) begin
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
        end else if (aw_fin && w_fin) begin
          awvalid_d = 1'b0;
          wvalid_d  = 1'b0;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          bready_d  = 1'b1;
          state_d   = StWrResp;
        end else begin
          awvalid_d = ~aw_fin;
          wvalid_d  = ~w_fin;
          aw_done_d = aw_fin;
          w_done_d  = w_fin;
        end
      end
      StWrResp: begin
        if (bus.m_axi_bvalid && bready_q) begin
          bready_d = 1'b0;
          if (bus.m_axi_bresp != 2'b00) err_sticky_d = 1'b1;
          if (idx_q == 6'd63) begin
            init_done_d = 1'b1;
            req_ready_d = 1'b1;
            state_d     = StRdIdle;
          end else begin
            idx_d     = idx_q + 6'd1;
            awaddr_d  = ADDR_W'({idx_d, 2'b00});
            wdata_d   = DATA_W'(product(idx_d));
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = StWr;
          end
        end
      end
      StRdIdle: begin
        init_done_d = 1'b1;
        req_ready_d = 1'b1;
        if (bus.req_valid && req_ready_q) begin
          req_ready_d = 1'b0;
          araddr_d    = ADDR_W'({bus.req_a, bus.req_b, 2'b00});
          arvalid_d   = 1'b1;
          state_d     = StRdAddr;
        end
      end
      StRdAddr: begin
        if (bus.m_axi_arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = StRdData;
        end
      end
      StRdData: begin
        if (bus.m_axi_rvalid) begin
          rready_d     = 1'b0;
          rsp_result_d = bus.m_axi_rdata[5:0];
          rsp_err_d    = (bus.m_axi_rresp != 2'b00);
          if (bus.m_axi_rresp != 2'b00) err_sticky_d = 1'b1;
          rsp_valid_d  = 1'b1;
          state_d      = StRsp;
        end
      end
      StRsp: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          req_ready_d = 1'b1;
          state_d     = StRdIdle;
        end
      end
      default: state_d = StRdIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= INIT_EN ? StWr : StRdIdle;
      idx_q        <= '0;
      aw_done_q    <= 1'b0;
      w_done_q     <= 1'b0;
      awvalid_q    <= 1'b0;
      wvalid_q     <= 1'b0;
      bready_q     <= 1'b0;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      awaddr_q     <= '0;
      araddr_q     <= '0;
      wdata_q      <= '0;
      req_ready_q  <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
      rsp_err_q    <= 1'b0;
      init_done_q  <= 1'b0;
      err_sticky_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      aw_done_q    <= aw_done_d;
      w_done_q     <= w_done_d;
      awvalid_q    <= awvalid_d;
      wvalid_q     <= wvalid_d;
      bready_q     <= bready_d;
      arvalid_q    <= arvalid_d;
      rready_q     <= rready_d;
      awaddr_q     <= awaddr_d;
      araddr_q     <= araddr_d;
      wdata_q      <= wdata_d;
      req_ready_q  <= req_ready_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      rsp_err_q    <= rsp_err_d;
      init_done_q  <= init_done_d;
      err_sticky_q <= err_sticky_d;
    end
  end

  assign bus.req_ready     = req_ready_q;
  assign bus.rsp_valid     = rsp_valid_q;
  assign bus.rsp_result    = rsp_result_q;
  assign bus.rsp_err       = rsp_err_q;
  assign bus.m_axi_awaddr  = awaddr_q;
  assign bus.m_axi_awvalid = awvalid_q;
  assign bus.m_axi_wdata   = wdata_q;
  assign bus.m_axi_wstrb   = 4'hF;
  assign bus.m_axi_wvalid  = wvalid_q;
  assign bus.m_axi_bready  = bready_q;
  assign bus.m_axi_araddr  = araddr_q;
  assign bus.m_axi_arvalid = arvalid_q;
  assign bus.m_axi_rready  = rready_q;
  assign init_done         = init_done_q;
  assign err_sticky        = err_sticky_q;

endmodule

// File: doc/times_table_seq.md
Name: times_table_seq

Overview:
- Sequencing controller for the AXI4-lite block-RAM multiplication table (0..7 x 0..7).
- After reset it acts as AXI4-lite master and writes all 64 products into memory, one word per entry.
- It then serves single-outstanding lookup requests (a, b) through a valid/ready front end.
- Each lookup is translated into one AXI read, and the 6-bit product is returned to the requester.
- Sits between user logic and the memory instance; it is the only master on the memory's AXI port.

Parameters:
- INIT_EN, 1, 1 = fill the table after every reset; 0 = skip fill and go straight to lookup service.
- ADDR_W, 32, AXI address width.
- DATA_W, 32, AXI data width; product zero-extended to it.

Ports:
- clk  in  1  single clock; also drives the memory's s_aclk.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  lookup request valid.
- req_ready  out  1  controller can accept a request.
- req_a  in  3  multiplicand.
- req_b  in  3  multiplier.
- rsp_valid  out  1  result valid; held until rsp_ready.
- rsp_ready  in  1  requester accepts the result.
- rsp_result  out  6  product, taken from rdata[5:0].
- rsp_err  out  1  rresp != OKAY for this response.
- init_done  out  1  table fill complete; lookups enabled.
- err_sticky  out  1  any bresp/rresp != OKAY since reset.
- m_axi_awaddr  out  ADDR_W  write address.
- m_axi_awvalid  out  1
- m_axi_awready  in  1
- m_axi_wdata  out  DATA_W  write data.
- m_axi_wstrb  out  4  always 4'hF.
- m_axi_wvalid  out  1
- m_axi_wready  in  1
- m_axi_bresp  in  2
- m_axi_bvalid  in  1
- m_axi_bready  out  1
- m_axi_araddr  out  ADDR_W  read address.
- m_axi_arvalid  out  1
- m_axi_arready  in  1
- m_axi_rdata  in  DATA_W
- m_axi_rresp  in  2
- m_axi_rvalid  in  1
- m_axi_rready  out  1

Behaviour:
- Address map: addr = {zeros, a[2:0], b[2:0], 2'b00}. Entry index i = {a,b}; byte address = 4*i.
- Reset (rst=1 at a clk edge): all outputs 0, counters 0.
  - Any in-flight transaction is abandoned; no valid survives the edge.
  - After release: state WR if INIT_EN=1, else RD_IDLE with init_done=1.
- Registers: every AXI output and every rsp_* output is registered.
- WR:
  - awvalid and wvalid are asserted together, with awaddr = 4*i and wdata = a*b (zero-extended).
  - Each valid drops independently on its own handshake (valid&ready), in any order or in the same cycle.
  - Once both handshakes are done, go to WR_RESP.
- WR_RESP:
  - bready=1.
  - On bvalid: if bresp != 0, set err_sticky.
  - If i==63: set init_done, go to RD_IDLE. Otherwise i++ and return to WR.
  - No write is re-issued on error.
- RD_IDLE:
  - req_ready = init_done.
  - On req_valid & req_ready: latch a and b, then go to RD_ADDR.
  - Only one request is outstanding at a time.
- RD_ADDR: arvalid=1 with latched address; on arready go to RD_DATA.
- RD_DATA:
  - rready=1.
  - On rvalid: latch rdata[5:0] into rsp_result and set rsp_err = (rresp != 0).
  - If rsp_err, also set err_sticky.
  - Go to RSP.
- RSP:
  - rsp_valid=1; rsp_result and rsp_err are held stable.
  - On rsp_ready: rsp_valid falls next cycle; go to RD_IDLE.
- req_ready is 0 outside RD_IDLE and 0 during init. Requests presented during init wait; none are dropped.
- Minimum lookup latency with AXI slave ready and rsp_ready high:
  - Accept edge -> arvalid next cycle -> rsp_valid 2 cycles after the AR handshake, given rvalid the cycle after AR.
- Fill time with slave always ready: 2 cycles per entry, 128 cycles total.
- Valid-stability rule: once raised, awvalid, wvalid and arvalid never drop before their handshake (except on rst).
- err_sticky is cleared only by rst.

Test Plan:
- Fill, slave always ready:
  - 64 AW/W handshakes at addresses 0x00..0xFC in order.
  - Entry addr 0xFC carries wdata 49; addr 0x54 ({2,5}) carries 10.
  - init_done rises after the 64th bvalid; err_sticky=0.
- Fill with skewed ready: wready asserted 3 cycles before awready on entry 0.
  - wvalid drops after its handshake; awvalid is held until awready.
  - Exactly one bready cycle per entry; final table is correct.
- Lookup a=7, b=6 after init:
  - araddr=0xF8; slave returns rdata=42 with OKAY.
  - rsp_result=42, rsp_err=0; req_ready stays low until RSP completes.
- Backpressure: rsp_ready held low 5 cycles with a=3, b=3.
  - rsp_valid held high and rsp_result=9 stable throughout.
  - A second req_valid is not accepted until after the rsp handshake.
- Reset mid-fill: rst pulsed while i=20 with awvalid high.
  - All AXI valids are 0 the cycle after the edge; init_done=0.
  - Fill restarts at address 0x00 after release.
- Error response: rresp=2'b10 on a lookup of 2x4.
  - rsp_result=8 with rsp_err=1, err_sticky=1.
  - err_sticky stays 1 across later OKAY reads until rst.
